// File: rtl/burst_qualifier.sv
// Burst qualifier: debounces a detect stream into bursts and reports each burst length
// through a valid/ready record port. Define BURST_TIMESTAMP_EN to add a start timestamp.
module burst_qualifier #(
  parameter int unsigned MIN_ON    = 4,
  parameter int unsigned MIN_OFF   = 8,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned TS_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 detect,
  output logic                 burstActive,
  output logic [LEN_WIDTH-1:0] lenData,
  output logic                 lenValid,
  input  logic                 lenReady,
  output logic                 dropped
`ifdef BURST_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]  tsData
`endif
);

  localparam int unsigned ON_W  = $clog2(MIN_ON + 1);
  localparam int unsigned OFF_W = $clog2(MIN_OFF + 1);
  localparam int unsigned SUM_W = LEN_WIDTH + OFF_W + 1;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, RELEASING} state_t;

  state_t               state_q = IDLE;
  state_t               state_d;
  logic [ON_W-1:0]      on_q    = '0;
  logic [ON_W-1:0]      on_d;
  logic [OFF_W-1:0]     off_q   = '0;
  logic [OFF_W-1:0]     off_d;
  logic [LEN_WIDTH-1:0] len_q   = '0;
  logic [LEN_WIDTH-1:0] len_d;
  logic                 active_q = 1'b0;
  logic                 valid_q  = 1'b0;
  logic [LEN_WIDTH-1:0] data_q   = '0;
  logic                 drop_q   = 1'b0;

  logic                 emit;
  logic                 load_rec;
  logic [ON_W-1:0]      on_inc;
  logic [OFF_W-1:0]     off_inc;
  logic [LEN_WIDTH-1:0] len_inc;
  logic [SUM_W-1:0]     gap_sum;
  logic [LEN_WIDTH-1:0] len_gap;

  assign on_inc  = on_q + ON_W'(1);
  assign off_inc = off_q + OFF_W'(1);
  assign len_inc = (len_q == LEN_MAX) ? LEN_MAX : len_q + LEN_WIDTH'(1);
  // Gap absorb: the low cycles plus the high sample that ends the gap.
  assign gap_sum = SUM_W'(len_q) + SUM_W'(off_q) + SUM_W'(1);
  assign len_gap = (gap_sum > SUM_W'(LEN_MAX)) ? LEN_MAX : gap_sum[LEN_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    off_d   = off_q;
    len_d   = len_q;
    emit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (detect) begin
          state_d = ARMING;
          on_d    = ON_W'(1);
          len_d   = LEN_WIDTH'(1);
        end
      end
      ARMING: begin
        if (detect) begin
          on_d  = on_inc;
          len_d = len_inc;
          if (on_inc == ON_W'(MIN_ON)) state_d = ACTIVE;
        end else begin
          state_d = IDLE;
          on_d    = '0;
          len_d   = '0;
        end
      end
      ACTIVE: begin
        if (detect) begin
          len_d = len_inc;
        end else begin
          state_d = RELEASING;
          off_d   = OFF_W'(1);
        end
      end
      RELEASING: begin
        if (detect) begin
          state_d = ACTIVE;
          len_d   = len_gap;
          off_d   = '0;
        end else if (off_inc == OFF_W'(MIN_OFF)) begin
          emit    = 1'b1;
          state_d = IDLE;
          on_d    = '0;
          off_d   = '0;
          len_d   = '0;
        end else begin
          off_d = off_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_rec = emit && (!valid_q || lenReady);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      on_q     <= '0;
      off_q    <= '0;
      len_q    <= '0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      on_q     <= on_d;
      off_q    <= off_d;
      len_q    <= len_d;
      active_q <= (state_d == ACTIVE) || (state_d == RELEASING);
      drop_q   <= emit && !load_rec;
      if (load_rec) begin
        data_q  <= len_q;
        valid_q <= 1'b1;
      end else if (valid_q && lenReady) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign burstActive = active_q;
  assign lenData     = data_q;
  assign lenValid    = valid_q;
  assign dropped     = drop_q;

`ifdef BURST_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_q   = '0;
  logic [TS_WIDTH-1:0] ts_start_q = '0;
  logic [TS_WIDTH-1:0] ts_data_q  = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q   <= '0;
      ts_start_q <= '0;
      ts_data_q  <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_WIDTH'(1);
      if (state_q == IDLE && detect) ts_start_q <= ts_cnt_q;
      if (load_rec) ts_data_q <= ts_start_q;
    end
  end

  assign tsData = ts_data_q;
`endif

endmodule

// File: tb/tb_burst_qualifier.sv
// Bench for burst_qualifier: directed scenarios plus random run-length stimulus against a
// run/time based reference model, on a default instance and a narrow short-window instance.
module tb_burst_qualifier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic detect = 1'b0;
  logic len_ready = 1'b0;

  logic        active_a, valid_a, drop_a;
  logic [15:0] data_a;
  logic        active_b, valid_b, drop_b;
  logic [3:0]  data_b;
`ifdef BURST_TIMESTAMP_EN
  logic [31:0] ts_a, ts_b;
`endif

  burst_qualifier u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .detect     (detect),
    .burstActive(active_a),
    .lenData    (data_a),
    .lenValid   (valid_a),
    .lenReady   (len_ready),
    .dropped    (drop_a)
`ifdef BURST_TIMESTAMP_EN
    ,
    .tsData     (ts_a)
`endif
  );

  burst_qualifier #(
    .MIN_ON   (2),
    .MIN_OFF  (3),
    .LEN_WIDTH(4)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .detect     (detect),
    .burstActive(active_b),
    .lenData    (data_b),
    .lenValid   (valid_b),
    .lenReady   (len_ready),
    .dropped    (drop_b)
`ifdef BURST_TIMESTAMP_EN
    ,
    .tsData     (ts_b)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned drops_a = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Model state: a burst is described by the sample index of its first and last high.
  typedef struct {
    bit     in_burst;
    longint hi_run;
    longint lo_run;
    longint start;
    longint last;
    longint n;
    bit     valid;
    longint data;
    longint tsd;
    bit     drop;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t model_step(input mdl_t m, input bit rs, input bit d, input bit rdy,
                                      input longint min_on, input longint min_off,
                                      input int lw);
    bit     emit;
    longint len;
    longint cap;
    mdl_t   z;
    z = '{default: 0};
    if (rs) return z;
    emit = 1'b0;
    len  = 0;
    cap  = (longint'(1) << lw) - 1;
    if (!m.in_burst) begin
      if (d) begin
        m.hi_run++;
        if (m.hi_run == min_on) begin
          m.in_burst = 1'b1;
          m.start    = m.n - min_on + 1;
          m.last     = m.n;
          m.lo_run   = 0;
        end
      end else begin
        m.hi_run = 0;
      end
    end else if (d) begin
      m.last   = m.n;
      m.lo_run = 0;
    end else begin
      m.lo_run++;
      if (m.lo_run == min_off) begin
        emit       = 1'b1;
        len        = m.last - m.start + 1;
        if (len > cap) len = cap;
        m.in_burst = 1'b0;
        m.hi_run   = 0;
      end
    end
    m.drop = 1'b0;
    if (emit) begin
      if (!m.valid || rdy) begin
        m.valid = 1'b1;
        m.data  = len;
        m.tsd   = m.start;
      end else begin
        m.drop = 1'b1;
      end
    end else if (m.valid && rdy) begin
      m.valid = 1'b0;
    end
    m.n++;
    return m;
  endfunction

  task automatic step(input bit d, input bit r, input bit rs);
    @(negedge clk);
    detect    = d;
    len_ready = r;
    rst       = rs;
    @(posedge clk);
    ma = model_step(ma, rs, d, r, 4, 8, 16);
    mb = model_step(mb, rs, d, r, 2, 3, 4);
    #1;
    check("a_active", active_a, ma.in_burst);
    check("a_valid",  valid_a,  ma.valid);
    check("a_data",   data_a,   ma.data);
    check("a_drop",   drop_a,   ma.drop);
    check("b_active", active_b, mb.in_burst);
    check("b_valid",  valid_b,  mb.valid);
    check("b_data",   data_b,   mb.data);
    check("b_drop",   drop_b,   mb.drop);
`ifdef BURST_TIMESTAMP_EN
    check("a_ts", ts_a, ma.tsd & 64'hFFFF_FFFF);
    check("b_ts", ts_b, mb.tsd & 64'hFFFF_FFFF);
`endif
    if (drop_a) drops_a++;
  endtask

  task automatic run(input int hi, input int lo, input bit r);
    repeat (hi) step(1'b1, r, 1'b0);
    repeat (lo) step(1'b0, r, 1'b0);
  endtask

  task automatic flush();
    repeat (12) step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    #1;
    check("pwr_active", active_a, 0);
    check("pwr_valid",  valid_a,  0);
    check("pwr_data",   data_a,   0);
    check("pwr_drop",   drop_a,   0);
    check("pwr_b_valid", valid_b, 0);

    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    flush();
    run(3, 20, 1'b1);
    check("glitch_valid", valid_a, 0);

    flush();
    run(10, 8, 1'b0);
    check("len10_valid", valid_a, 1);
    check("len10_data",  data_a,  10);

    flush();
    run(6, 5, 1'b0);
    run(4, 8, 1'b0);
    check("gap_valid", valid_a, 1);
    check("gap_data",  data_a,  15);

    flush();
    drops_a = 0;
    run(10, 8, 1'b0);
    run(12, 8, 1'b0);
    check("hold_data",  data_a,  10);
    check("hold_valid", valid_a, 1);
    check("drop_count", drops_a, 1);
    step(1'b0, 1'b1, 1'b0);
    check("accept_clear", valid_a, 0);

    flush();
    run(20, 8, 1'b0);
    check("sat_b_data", data_b, 15);
    check("sat_a_data", data_a, 20);

    flush();
    run(6, 0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("rst_active", active_a, 0);
    check("rst_valid",  valid_a,  0);
    check("rst_data",   data_a,   0);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    run(10, 8, 1'b0);
    check("post_rst_data", data_a, 10);
`ifdef BURST_TIMESTAMP_EN
    check("post_rst_ts", ts_a, 5);
`endif

    for (int i = 0; i < 300; i++) begin
      int hi;
      int lo;
      int mode;
      hi   = $urandom_range(1, 20);
      lo   = $urandom_range(1, 14);
      mode = $urandom_range(0, 3);
      repeat (hi) step(1'b1, (mode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 199) == 0));
      repeat (lo) step(1'b0, (mode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/burst_qualifier.md
BURST_QUALIFIER -- requirements
Module: burst_qualifier

Interface
REQ-001 The block SHALL have the parameter MIN_ON, default 4, giving the consecutive high samples needed to qualify a burst (legal range >= 2).
REQ-002 The block SHALL have the parameter MIN_OFF, default 8, giving the consecutive low samples needed to end a burst (legal range >= 2).
REQ-003 The block SHALL have the parameter LEN_WIDTH, default 16, giving the width of the burst-length field.
REQ-004 The block SHALL have the parameter TS_WIDTH, default 32, giving the width of the timestamp field.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port detect, input, 1 bit: the hysteresis detect bit from the upstream threshold stage.
REQ-008 The block SHALL have port burstActive, output, 1 bit: a qualified burst is in progress.
REQ-009 The block SHALL have port lenData, output, LEN_WIDTH bits: the length of the completed burst in cycles.
REQ-010 The block SHALL have port lenValid, output, 1 bit: the record on lenData is valid.
REQ-011 The block SHALL have port lenReady, input, 1 bit: the consumer accepts the record.
REQ-012 The block SHALL have port dropped, output, 1 bit: one-cycle pulse when a completed record is discarded.
REQ-013 The block SHALL have port tsData, output, TS_WIDTH bits, present only with BURST_TIMESTAMP_EN: the burst start timestamp.

Function
REQ-014 detect SHALL be sampled on every rising clk edge; the FSM SHALL have the states IDLE, ARMING, ACTIVE and RELEASING.
REQ-015 In IDLE, detect=1 SHALL move the FSM to ARMING with onCnt=1 and lenCnt=1.
REQ-016 In ARMING, detect=1 SHALL increment onCnt and lenCnt and enter ACTIVE when the new onCnt equals MIN_ON; detect=0 SHALL return to IDLE with no record (glitch rejected).
REQ-017 In ACTIVE, detect=1 SHALL increment lenCnt; detect=0 SHALL enter RELEASING with offCnt=1.
REQ-018 In RELEASING, detect=1 SHALL return to ACTIVE with lenCnt += offCnt+1 (gap absorbed); detect=0 SHALL increment offCnt.
REQ-019 In RELEASING, when the incremented offCnt equals MIN_OFF, the block SHALL emit a record and enter IDLE.
REQ-020 The reported length SHALL be the count of cycles from the first high sample to the last high sample, inclusive.
REQ-021 lenCnt and the reported length SHALL saturate at 2^LEN_WIDTH-1 and SHALL never wrap.
REQ-022 burstActive SHALL be a registered output equal to 1 exactly while the FSM is in ACTIVE or RELEASING, so it rises on the cycle after the MIN_ON-th high sample.
REQ-023 On emission, lenData SHALL load the reported length and lenValid SHALL assert on the following cycle.
REQ-024 lenValid and lenData SHALL be held stable until a cycle with lenValid=1 and lenReady=1, after which lenValid SHALL clear.
REQ-025 If an emission coincides with lenValid=1 and lenReady=1, the new record SHALL load and lenValid SHALL stay 1.
REQ-026 If an emission coincides with lenValid=1 and lenReady=0, the new record SHALL be discarded, lenData SHALL remain unchanged, and dropped SHALL pulse for one cycle.
REQ-027 A new burst SHALL be qualifiable in the cycle immediately after emission, independent of the output handshake.

Reset
REQ-028 While rst=1, the FSM SHALL be IDLE, all counters SHALL be 0, and burstActive, lenValid and dropped SHALL be 0, with lenData=0 (and tsData=0 when the macro is defined).
REQ-029 Reset asserted mid-burst SHALL abandon the burst with no record and no dropped pulse.
REQ-030 Outputs SHALL be 0 from power-up (initial values) before the first reset.

Configuration
REQ-031 With BURST_TIMESTAMP_EN defined, the block SHALL include a free-running TS_WIDTH counter that is cleared by rst, wraps modulo 2^TS_WIDTH, and is captured on the IDLE->ARMING transition.
REQ-032 With BURST_TIMESTAMP_EN defined, tsData SHALL be loaded alongside lenData under the same handshake and drop rules.
REQ-033 Without BURST_TIMESTAMP_EN, the tsData port and the timestamp counter SHALL be absent and all other behaviour SHALL be identical.

Verification (MIN_ON=4, MIN_OFF=8 unless stated)
REQ-034 Scenario: detect high 3 cycles then low 20 cycles -> burstActive stays 0, no lenValid, no dropped.
REQ-035 Scenario: detect high 10 cycles then low 8 cycles -> burstActive rises the cycle after the 4th high sample; lenValid=1 with lenData=10 the cycle after the 8th low sample.
REQ-036 Scenario: detect high 6, low 5, high 4, low 8 -> exactly one record with lenData=15.
REQ-037 Scenario: lenReady=0, bursts of 10 then 12 -> lenData stays 10, dropped pulses once; then lenReady=1 -> lenValid clears after one cycle.
REQ-038 Scenario: LEN_WIDTH=4, detect high 20 cycles then low 8 -> lenData=15.
REQ-039 Scenario: rst pulsed while in ACTIVE after 6 high cycles -> all outputs 0 next cycle, no record; with the macro defined, the next burst starting 5 cycles after reset release gives tsData=5.
